// File: rtl/uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_periph
// Purpose  : APB responder that queues bytes in a small TX FIFO and
//            serialises them onto an 8N1 UART line, LSB first, with a
//            software-programmable baud divisor.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_periph #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx,
  output logic        tx_busy
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // APB decode: one wait state, register effects land on the edge ending PREADY
  logic       access;
  logic       wr_en;
  logic       rd_en;
  logic [1:0] reg_sel;

  assign access  = PSEL & PENABLE;
  assign wr_en   = access & PWRITE & PREADY;
  assign rd_en   = access & ~PWRITE & ~PREADY;
  assign reg_sel = PADDR[3:2];

  // Control and configuration registers
  logic        en;
  logic        ovr;
  logic [15:0] baud_div;

  // FIFO storage and bookkeeping
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          do_push;
  logic          pop;
  logic          flush;
  logic          ovr_clr;
  logic [7:0]    head;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign head     = mem[rptr];
  assign push_req = wr_en && (reg_sel == REG_TXDATA);
  assign flush    = wr_en && (reg_sel == REG_CTRL) && PWDATA[1];
  assign ovr_clr  = wr_en && (reg_sel == REG_CTRL) && PWDATA[2];
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign do_push  = push_req && !flush && (!full || pop);

  // Transmitter state
  state_t      state;
  state_t      state_nxt;
  logic [7:0]  shreg;
  logic [15:0] div_lat;
  logic [15:0] bit_timer;
  logic [2:0]  bit_idx;
  logic        bit_end;

  assign bit_end = (bit_timer == 16'd0);
  assign tx_busy = (state != S_IDLE);

  // Software-visible registers: EN, sticky overrun flag and baud divisor
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      en       <= 1'b0;
      ovr      <= 1'b0;
      baud_div <= DEFAULT_DIV;
    end else begin
      if (wr_en && (reg_sel == REG_CTRL)) en <= PWDATA[0];
      if (wr_en && (reg_sel == REG_BAUD)) baud_div <= PWDATA[15:0];
      if (ovr_clr)
        ovr <= 1'b0;
      else if (push_req && !flush && full && !pop)
        ovr <= 1'b1;
    end
  end

  // FIFO data array; contents need no reset since COUNT gates visibility
  always_ff @(posedge PCLK) begin
    if (do_push) mem[wptr] <= PWDATA[7:0];
  end

  // FIFO pointers and occupancy; flush wins over any concurrent push or pop
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= wptr;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      if (do_push && !pop)
        count <= count + (AW+1)'(1);
      else if (!do_push && pop)
        count <= count - (AW+1)'(1);
    end
  end

  // APB handshake and registered read data
  logic [31:0] rdata_mux;
  logic [31:0] count_ext;
  assign count_ext = 32'(count);

  // Read mux; write-only and self-clearing fields read as zero
  always_comb begin
    rdata_mux = 32'd0;
    case (reg_sel)
      REG_CTRL:   rdata_mux = {31'd0, en};
      REG_STATUS: rdata_mux = {24'd0, count_ext[3:0], ovr, tx_busy, empty, full};
      REG_TXDATA: rdata_mux = 32'd0;
      REG_BAUD:   rdata_mux = {16'd0, baud_div};
      default:    rdata_mux = 32'd0;
    endcase
  end

  // PREADY pulses once per transfer; PRDATA is captured on its rising edge
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      PREADY <= 1'b0;
      PRDATA <= 32'd0;
    end else begin
      PREADY <= access & ~PREADY;
      PRDATA <= rd_en ? rdata_mux : 32'd0;
    end
  end

  // TX FSM state register
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // TX FSM next state and pop decision; STOP chains straight into START
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && !empty) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_idx == 3'd7)) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (en && !empty) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit timer, divisor snapshot and shift register; divisor sampled per frame
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      shreg     <= 8'd0;
      div_lat   <= DEFAULT_DIV;
      bit_timer <= 16'd0;
      bit_idx   <= 3'd0;
    end else if (pop) begin
      shreg     <= head;
      div_lat   <= baud_div;
      bit_timer <= baud_div;
      bit_idx   <= 3'd0;
    end else if (state != S_IDLE) begin
      if (bit_end) begin
        bit_timer <= div_lat;
        if (state == S_DATA) bit_idx <= bit_idx + 3'd1;
      end else begin
        bit_timer <= bit_timer - 16'd1;
      end
    end
  end

  // Line driver: idle and stop are high, start is low, data is LSB first
  always_comb begin
    tx = 1'b1;
    case (state)
      S_START: tx = 1'b0;
      S_DATA:  tx = shreg[bit_idx];
      default: tx = 1'b1;
    endcase
  end

  // Address byte lane and upper write-data bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:16], count_ext[31:4]};

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_periph
// Purpose  : Directed self-checking bench for uart_tx_periph.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_periph;

  logic        pclk;
  logic        preset_n;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        penable;
  logic        psel;
  logic [31:0] prdata;
  logic        pready;
  logic        tx;
  logic        tx_busy;

  int n_checks;
  int n_fail;
  int busy_cnt;

  uart_tx_periph #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd867)) dut (
    .PCLK    (pclk),
    .PRESET  (preset_n),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PWRITE  (pwrite),
    .PENABLE (penable),
    .PSEL    (psel),
    .PRDATA  (prdata),
    .PREADY  (pready),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Free-running count of clock edges that see tx_busy high
  initial busy_cnt = 0;
  always @(posedge pclk) if (tx_busy) busy_cnt <= busy_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [3:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    logic seen;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge pclk);
    penable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      if (pready) begin
        seen = 1'b1;
        break;
      end
    end
    rdata = prdata;
    check_eq("apb_pready", 32'(seen), 32'd1);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_wr(input logic [3:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    apb_xfer(1'b1, addr, wdata, dummy);
  endtask

  task automatic apb_rd(input logic [3:0] addr, output logic [31:0] rdata);
    apb_xfer(1'b0, addr, 32'd0, rdata);
  endtask

  // Poll for the start bit; returns half a cycle into it
  task automatic wait_start(input string tag, input int bound);
    logic found;
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge pclk);
      if (!tx) begin
        found = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  // Sample start, 8 data bits and stop, one sample per bit period
  task automatic sample_frame(input int p, output logic [9:0] v);
    v[0] = tx;
    for (int i = 1; i < 10; i++) begin
      repeat (p) @(negedge pclk);
      v[i] = tx;
    end
  endtask

  task automatic wait_idle(input string tag);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pclk);
      if (!tx_busy) begin
        idle = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(idle), 32'd1);
  endtask

  logic [31:0] rd;
  logic [9:0]  fv;
  int          b0;
  logic [7:0]  exp_bytes [4];

  initial begin
    n_checks = 0; n_fail = 0;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h44;

    // Reset values
    preset_n = 1'b0;
    repeat (3) @(negedge pclk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_pready", 32'(pready), 32'd0);
    check_eq("rst_prdata", prdata, 32'd0);
    preset_n = 1'b1;
    apb_rd(4'h4, rd); check_eq("rst_status", rd, 32'h02);
    apb_rd(4'h0, rd); check_eq("rst_ctrl", rd, 32'h0);
    apb_rd(4'hC, rd); check_eq("rst_baud", rd, 32'd867);
    apb_rd(4'h8, rd); check_eq("txdata_reads0", rd, 32'h0);

    // Single frame 0xA5 at 4 cycles/bit, first-byte latency and busy width
    apb_wr(4'hC, 32'd3);
    apb_wr(4'h0, 32'h1);
    b0 = busy_cnt;
    apb_wr(4'h8, 32'hFFFF_FFA5);
    @(negedge pclk);
    check_eq("first_byte_latency", 32'(tx), 32'd0);
    sample_frame(4, fv);
    check_eq("frame_a5", 32'(fv), 32'h34A);
    wait_idle("a5_idle");
    check_eq("a5_busy_cycles", 32'(busy_cnt - b0), 32'd40);

    // Overrun with EN=0, then drain four frames back-to-back
    apb_wr(4'h0, 32'h0);
    apb_wr(4'hC, 32'd1);
    apb_wr(4'h8, 32'h11); apb_wr(4'h8, 32'h22); apb_wr(4'h8, 32'h33);
    apb_wr(4'h8, 32'h44); apb_wr(4'h8, 32'h55);
    apb_rd(4'h4, rd); check_eq("ovr_status", rd, 32'h49);
    apb_wr(4'h0, 32'h1);
    wait_start("b2b_start", 20);
    for (int k = 0; k < 4; k++) begin
      sample_frame(2, fv);
      check_eq($sformatf("b2b_frame%0d", k), 32'(fv), 32'({1'b1, exp_bytes[k], 1'b0}));
      repeat (2) @(negedge pclk);
      if (k < 3) check_eq($sformatf("b2b_gap%0d", k), 32'(tx), 32'd0);
    end
    check_eq("b2b_no_fifth", 32'(tx_busy), 32'd0);
    apb_rd(4'h4, rd); check_eq("drain_status", rd, 32'h0A);
    apb_wr(4'h0, 32'h5);
    apb_rd(4'h4, rd); check_eq("ovr_clr_status", rd, 32'h02);
    apb_rd(4'h0, rd); check_eq("ctrl_selfclear", rd, 32'h1);

    // Divisor change mid-frame applies only to the next frame
    apb_wr(4'hC, 32'd5);
    fork
      begin
        wait_start("div_start", 30);
        sample_frame(6, fv);
        check_eq("div_old_frame", 32'(fv), 32'h3FE);
        repeat (6) @(negedge pclk);
        check_eq("div_gap", 32'(tx), 32'd0);
        sample_frame(1, fv);
        check_eq("div_new_frame", 32'(fv), 32'h200);
      end
      begin
        apb_wr(4'h8, 32'hFF);
        apb_wr(4'hC, 32'd0);
        apb_wr(4'h8, 32'h00);
      end
    join
    wait_idle("div_idle");

    // Flush during the first of three queued frames
    apb_wr(4'hC, 32'd3);
    fork
      begin
        wait_start("flush_start", 30);
        sample_frame(4, fv);
        check_eq("flush_frame", 32'(fv), 32'h278);
        repeat (4) @(negedge pclk);
        check_eq("flush_tx_high", 32'(tx), 32'd1);
        check_eq("flush_not_busy", 32'(tx_busy), 32'd0);
      end
      begin
        apb_wr(4'h8, 32'h3C); apb_wr(4'h8, 32'h5A); apb_wr(4'h8, 32'h99);
        apb_rd(4'h4, rd); check_eq("preflush_status", rd, 32'h24);
        apb_wr(4'h0, 32'h3);
      end
    join
    apb_rd(4'h4, rd); check_eq("flush_status", rd, 32'h02);

    // Asynchronous reset in the middle of a data bit
    apb_wr(4'h0, 32'h0);
    apb_wr(4'h8, 32'hF0); apb_wr(4'h8, 32'h81);
    apb_rd(4'h4, rd); check_eq("prerst_status", rd, 32'h20);
    apb_wr(4'h0, 32'h1);
    wait_start("rst_frame_start", 20);
    repeat (8) @(negedge pclk);
    check_eq("mid_bit1_tx", 32'(tx), 32'd0);
    #1 preset_n = 1'b0;
    #1;
    check_eq("async_rst_tx", 32'(tx), 32'd1);
    check_eq("async_rst_busy", 32'(tx_busy), 32'd0);
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    apb_rd(4'h4, rd); check_eq("post_rst_status", rd, 32'h02);
    apb_rd(4'h0, rd); check_eq("post_rst_ctrl", rd, 32'h0);
    apb_rd(4'hC, rd); check_eq("post_rst_baud", rd, 32'd867);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
